mbssoc_apic: RTL



---
 rtl/mbssoc_apic_pkg.sv | 38 +++
 rtl/mbssoc_apic_core_seq.sv | 92 +++++++++
 rtl/mbssoc_apic.sv | 104 ++++++++++
 3 files changed

// File: rtl/mbssoc_apic_pkg.sv
// mbssoc_apic shared definitions: ctrl_bus strobe indices,
// conf field offsets, FSM encodings and the vector selector.
package mbssoc_apic_pkg;

  localparam int CORE_NUM = 2;

  localparam int CB_CONF = 2;
  localparam int CB_PC0  = 3;
  localparam int CB_PC1  = 4;
  localparam int CB_INV  = 5;

  localparam int MASK_LSB  = 0;
  localparam int ROUTE_LSB = 8;
  localparam int START_LSB = 16;

  typedef enum logic [1:0] {
    BOOT_HALT = 2'd0,
    BOOT_LOAD = 2'd1,
    BOOT_RUN  = 2'd2
  } boot_e;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_e;

  function automatic logic [2:0] lowest_idx(
    input logic [7:0] v
  );
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mbssoc_apic_core_seq.sv
// One core's boot sequencer (HALT/LOAD/RUN) and
// interrupt request FSM (IDLE/REQ).
module mbssoc_apic_core_seq
  import mbssoc_apic_pkg::*;
#(
  parameter boot_e BOOT_INIT = BOOT_HALT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       conf_wr,
  input  logic       start,
  input  logic       cand_any,
  input  logic [2:0] cand_idx,
  input  logic       ack,
  output logic       core_rst_n,
  output logic       pc_load,
  output logic       irq,
  output logic [2:0] vec,
  output logic       pend_clr
);

  boot_e boot;
  irq_e  ist;
  logic  run;

  assign run      = (boot == BOOT_RUN);
  assign pend_clr = (ist == IRQ_REQ) && ack;

  // LOAD entered from reset waits one cycle with pc_load low,
  // so the pulse lands in the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      boot       <= BOOT_INIT;
      core_rst_n <= 1'b0;
      pc_load    <= 1'b0;
    end else begin
      unique case (boot)
        BOOT_HALT: begin
          if (conf_wr && start) begin
            boot    <= BOOT_LOAD;
            pc_load <= 1'b1;
          end
        end
        BOOT_LOAD: begin
          if (!pc_load) begin
            pc_load <= 1'b1;
          end else begin
            boot       <= BOOT_RUN;
            pc_load    <= 1'b0;
            core_rst_n <= 1'b1;
          end
        end
        BOOT_RUN: begin
          if (conf_wr && !start) begin
            boot       <= BOOT_HALT;
            core_rst_n <= 1'b0;
          end
        end
        default: begin
          boot       <= BOOT_HALT;
          core_rst_n <= 1'b0;
          pc_load    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ist <= IRQ_IDLE;
      irq <= 1'b0;
      vec <= '0;
    end else begin
      unique case (ist)
        IRQ_IDLE: begin
          if (run && cand_any) begin
            vec <= cand_idx;
            ist <= IRQ_REQ;
            irq <= 1'b1;
          end
        end
        IRQ_REQ: begin
          if (ack || !run) begin
            ist <= IRQ_IDLE;
            irq <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mbssoc_apic.sv
// APIC: conf/PC registers, strobe edge capture, pending
// interrupts and per-core boot/irq sequencing.
module mbssoc_apic
  import mbssoc_apic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IRQ_NUM    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            ctrl_bus,
  input  logic [DATA_WIDTH-1:0] data_bus,
  input  logic [IRQ_NUM-1:0]    irq_in,
  input  logic [1:0]            cpu_irq_ack,
  output logic [1:0]            cpu_rst_n,
  output logic [1:0]            cpu_pc_load,
  output logic [DATA_WIDTH-1:0] cpu0_pc,
  output logic [DATA_WIDTH-1:0] cpu1_pc,
  output logic [1:0]            cpu_irq,
  output logic [5:0]            cpu_irq_vec
);

  logic [2:0]         cb_q;
  logic [2:0]         rise;
  logic               conf_wr;
  logic               pc0_wr;
  logic               pc1_wr;
  logic [IRQ_NUM-1:0] irq_q;
  logic [IRQ_NUM-1:0] pend;
  logic [IRQ_NUM-1:0] clr;
  logic [IRQ_NUM-1:0] mask_q;
  logic [IRQ_NUM-1:0] route_q;
  logic [CORE_NUM-1:0] clr_v;
  logic [2:0]         vec_a [CORE_NUM];
  logic               unused_ok;

  assign unused_ok = ^ctrl_bus[1:0];

  assign rise    = ctrl_bus[CB_PC1:CB_CONF] & ~cb_q;
  assign conf_wr = rise[0] & ~ctrl_bus[CB_INV];
  assign pc0_wr  = rise[1] & ~ctrl_bus[CB_INV];
  assign pc1_wr  = rise[2] & ~ctrl_bus[CB_INV];

  always_comb begin
    clr = '0;
    for (int n = 0; n < CORE_NUM; n++) begin
      for (int i = 0; i < IRQ_NUM; i++) begin
        if (clr_v[n] && vec_a[n] == 3'(i)) clr[i] = 1'b1;
      end
    end
  end

  // A new edge overrides an ack clear of the same bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cb_q    <= '0;
      irq_q   <= '0;
      pend    <= '0;
      mask_q  <= '0;
      route_q <= '0;
      cpu0_pc <= RESET_PC;
      cpu1_pc <= RESET_PC;
    end else begin
      cb_q  <= ctrl_bus[CB_PC1:CB_CONF];
      irq_q <= irq_in;
      pend  <= (pend & ~clr) | (irq_in & ~irq_q);
      if (conf_wr) begin
        mask_q  <= data_bus[MASK_LSB +: IRQ_NUM];
        route_q <= data_bus[ROUTE_LSB +: IRQ_NUM];
      end
      if (pc0_wr) cpu0_pc <= data_bus;
      if (pc1_wr) cpu1_pc <= data_bus;
    end
  end

  for (genvar g = 0; g < CORE_NUM; g++) begin : g_core
    logic [IRQ_NUM-1:0] cand;
    logic [7:0]         cand_w;

    assign cand   = pend & mask_q & (g == 0 ? ~route_q : route_q);
    assign cand_w = 8'(cand);

    mbssoc_apic_core_seq #(
      .BOOT_INIT(g == 0 ? BOOT_LOAD : BOOT_HALT)
    ) u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .conf_wr    (conf_wr),
      .start      (data_bus[START_LSB + g]),
      .cand_any   (|cand),
      .cand_idx   (lowest_idx(cand_w)),
      .ack        (cpu_irq_ack[g]),
      .core_rst_n (cpu_rst_n[g]),
      .pc_load    (cpu_pc_load[g]),
      .irq        (cpu_irq[g]),
      .vec        (vec_a[g]),
      .pend_clr   (clr_v[g])
    );

    assign cpu_irq_vec[3*g +: 3] = vec_a[g];
  end

endmodule
